// File: rtl/gate_bank_sequencer.sv
// rtl/gate_bank_sequencer.sv - truth-table self-test sequencer for the eight-gate logic bank
// Walks the four (a,b) vectors, settles, samples GATE_OUT and accumulates a sticky per-gate fail mask.
module gate_bank_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  GATE_OUT,
  output logic [14:0] GATE_IN,
  output logic [1:0]  VEC_IDX,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  FAIL_MASK
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [14:0] gate_in_q, gate_in_d;
  logic [1:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  fail_q, fail_d;
  logic        pass_q, pass_d;

  logic [7:0]  expect_out;
  logic [7:0]  care;
  logic [7:0]  mismatch;

  // I1 pins, NOT input and TRI data carry a; I2 pins and TRI enable carry b.
  function automatic logic [14:0] drive_for(input logic [1:0] k);
    logic a;
    logic b;
    a = k[0];
    b = k[1];
    return {b, a, b, a, b, a, b, a, b, a, a, b, a, b, a};
  endfunction

  always_comb begin
    expect_out = {vec_q[0], ~(vec_q[0] ^ vec_q[1]), vec_q[0] ^ vec_q[1],
                  ~(vec_q[0] | vec_q[1]), ~(vec_q[0] & vec_q[1]), ~vec_q[0],
                  vec_q[0] | vec_q[1], vec_q[0] & vec_q[1]};
    // The TRI output floats while its enable (b) is low, so it cannot be judged then.
    care = vec_q[1] ? 8'hFF : 8'h7F;
  end

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < 8; i++) begin
      mismatch[i] = care[i] & (GATE_OUT[i] !== expect_out[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    gate_in_d = gate_in_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE: begin
        gate_in_d = '0;
        if (START) begin
          state_d   = S_APPLY;
          vec_d     = 2'd0;
          fail_d    = '0;
          pass_d    = 1'b0;
          gate_in_d = drive_for(2'd0);
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        fail_d = fail_q | mismatch;
        if (vec_q == 2'd3) begin
          state_d = S_FINISH;
        end else begin
          vec_d     = vec_q + 2'd1;
          gate_in_d = drive_for(vec_q + 2'd1);
          state_d   = S_APPLY;
        end
      end
      S_FINISH: begin
        pass_d    = (fail_q == 8'h00);
        gate_in_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      gate_in_q <= '0;
      vec_q     <= 2'd0;
      cnt_q     <= 8'd0;
      fail_q    <= 8'd0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_in_q <= gate_in_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      pass_q    <= pass_d;
    end
  end

  assign GATE_IN   = gate_in_q;
  assign VEC_IDX   = vec_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FINISH);
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_q;

endmodule

// File: tb/tb_gate_bank_sequencer.sv
// tb/tb_gate_bank_sequencer.sv - randomized self-checking bench for gate_bank_sequencer
// Two instances (settle 2 with an instant bank, settle 5 with a 4-cycle bank) against a truth-table model.
module tb_gate_bank_sequencer;

  logic        clk;
  logic        rst;
  logic        start2, start5;
  logic [7:0]  gout2, gout5;
  logic [14:0] gi2, gi5;
  logic [1:0]  vec2, vec5;
  logic        busy2, busy5, done2, done5, pass2, pass5;
  logic [7:0]  fm2, fm5;

  logic [7:0]  s0_cfg, s1_cfg;
  logic        tri_float;
  logic        noise_q;
  logic [7:0]  pipe_q [4];
  logic        sel;

  int n_cmp;
  int n_err;

  gate_bank_sequencer #(.SETTLE_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .START(start2), .GATE_OUT(gout2),
    .GATE_IN(gi2), .VEC_IDX(vec2), .BUSY(busy2), .DONE(done2),
    .PASS(pass2), .FAIL_MASK(fm2)
  );

  gate_bank_sequencer #(.SETTLE_CYCLES(5)) dut5 (
    .CLK(clk), .RST(rst), .START(start5), .GATE_OUT(gout5),
    .GATE_IN(gi5), .VEC_IDX(vec5), .BUSY(busy5), .DONE(done5),
    .PASS(pass5), .FAIL_MASK(fm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bank_eval(input logic [14:0] gi, input logic [7:0] s0,
                                           input logic [7:0] s1, input logic flt, input logic nz);
    logic [7:0] o;
    o[0] = gi[0] & gi[1];
    o[1] = gi[2] | gi[3];
    o[2] = ~gi[4];
    o[3] = ~(gi[5] & gi[6]);
    o[4] = ~(gi[7] | gi[8]);
    o[5] = gi[9] ^ gi[10];
    o[6] = ~(gi[11] ^ gi[12]);
    o[7] = gi[14] ? gi[13] : (flt ? nz : 1'b0);
    return (o & ~s0) | s1;
  endfunction

  always_comb gout2 = bank_eval(gi2, s0_cfg, s1_cfg, tri_float, noise_q);
  assign gout5 = pipe_q[3];

  always @(posedge clk) begin
    noise_q   <= 1'($urandom_range(0, 1));
    pipe_q[0] <= bank_eval(gi5, s0_cfg, s1_cfg, tri_float, noise_q);
    pipe_q[1] <= pipe_q[0];
    pipe_q[2] <= pipe_q[1];
    pipe_q[3] <= pipe_q[2];
  end

  wire [14:0] obs_gi   = sel ? gi5 : gi2;
  wire [1:0]  obs_vec  = sel ? vec5 : vec2;
  wire        obs_busy = sel ? busy5 : busy2;
  wire        obs_done = sel ? done5 : done2;
  wire        obs_pass = sel ? pass5 : pass2;
  wire [7:0]  obs_fm   = sel ? fm5 : fm2;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] vec_word(input int k);
    logic [14:0] w;
    w = 15'h0000;
    if (k % 2 == 1) w = w | 15'h2AB5;
    if (k / 2 == 1) w = w | 15'h554A;
    return w;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [7:0] s0, input logic [7:0] s1);
    logic [7:0] m, ideal, seen, care;
    int a, b;
    m = 8'h00;
    for (int k = 0; k < 4; k++) begin
      a = k % 2;
      b = k / 2;
      ideal[0] = 1'(a & b);
      ideal[1] = 1'(a | b);
      ideal[2] = 1'(1 - a);
      ideal[3] = 1'(1 - (a & b));
      ideal[4] = 1'(1 - (a | b));
      ideal[5] = 1'(a != b);
      ideal[6] = 1'(a == b);
      ideal[7] = 1'(a);
      seen = (ideal & ~s0) | s1;
      care = (b == 1) ? 8'hFF : 8'h7F;
      m = m | ((seen ^ ideal) & care);
    end
    return m;
  endfunction

  task automatic drive_start(input logic use5, input logic v);
    if (use5) start5 = v;
    else start2 = v;
  endtask

  // Caller raises START at a negedge; the next posedge is edge 0. Returns at a negedge.
  task automatic run_once(input logic use5, input logic hold_next, input logic noisy);
    int s, l, k;
    logic [7:0] em;
    sel = use5;
    s  = use5 ? 5 : 2;
    l  = 4 * (s + 2) + 1;
    em = ref_mask(s0_cfg, s1_cfg);
    for (int c = 1; c <= l + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      k = (c < l) ? (c - 1) / (s + 2) : 3;
      if (c <= l) begin
        expect_eq("gate_in", 32'(obs_gi), 32'(vec_word(k)));
        expect_eq("vec_idx", 32'(obs_vec), 32'(k));
        expect_eq("pass_cleared", 32'(obs_pass), 32'd0);
      end else begin
        expect_eq("gate_in_idle", 32'(obs_gi), 32'd0);
        expect_eq("pass", 32'(obs_pass), 32'(em == 8'h00));
        expect_eq("fail_mask_hold", 32'(obs_fm), 32'(em));
      end
      expect_eq("busy", 32'(obs_busy), 32'(c <= l));
      expect_eq("done", 32'(obs_done), 32'(c == l));
      if (c == l) expect_eq("fail_mask", 32'(obs_fm), 32'(em));
      if (c < l) drive_start(use5, noisy && ($urandom_range(0, 3) == 0));
      else drive_start(use5, hold_next);
    end
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, "_gate_in"}, 32'(obs_gi), 32'd0);
    expect_eq({tag, "_vec_idx"}, 32'(obs_vec), 32'd0);
    expect_eq({tag, "_busy"}, 32'(obs_busy), 32'd0);
    expect_eq({tag, "_done"}, 32'(obs_done), 32'd0);
    expect_eq({tag, "_pass"}, 32'(obs_pass), 32'd0);
    expect_eq({tag, "_fail_mask"}, 32'(obs_fm), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start2 = 1'b0;
    start5 = 1'b0;
    s0_cfg = 8'h00;
    s1_cfg = 8'h00;
    tri_float = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check_all_zero("reset2");
    sel = 1'b1;
    check_all_zero("reset5");
    rst = 1'b0;
    @(negedge clk);

    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b0, 1'b0);

    s0_cfg = 8'h20;
    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b0, 1'b0);
    expect_eq("xor_stuck_mask", 32'(fm2), 32'h20);

    s0_cfg = 8'h00;
    tri_float = 1'b1;
    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b0, 1'b0);
    expect_eq("tri_float_pass", 32'(pass2), 32'd1);

    s0_cfg = 8'h80;
    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b0, 1'b0);
    expect_eq("tri_stuck_mask", 32'(fm2), 32'h80);

    s0_cfg = 8'h00;
    tri_float = 1'b0;
    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b1, 1'b0);
    run_once(1'b0, 1'b0, 1'b0);

    s0_cfg = 8'h02;
    sel = 1'b0;
    drive_start(1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      expect_eq("rst_run_busy", 32'(busy2), 32'd1);
      expect_eq("rst_run_gate_in", 32'(gi2), 32'(vec_word((c - 1) / 4)));
      drive_start(1'b0, c == 5);
      if (c == 9) rst = 1'b1;
    end
    expect_eq("rst_run_mask_before", 32'(fm2), 32'h02);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_reset");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      expect_eq("post_reset_done", 32'(done2), 32'd0);
      expect_eq("post_reset_busy", 32'(busy2), 32'd0);
    end
    s0_cfg = 8'h00;
    drive_start(1'b0, 1'b1);
    run_once(1'b0, 1'b0, 1'b0);

    drive_start(1'b1, 1'b1);
    run_once(1'b1, 1'b0, 1'b0);
    expect_eq("settle5_pass", 32'(pass5), 32'd1);

    for (int r = 0; r < 8; r++) begin
      logic u5;
      u5 = 1'($urandom_range(0, 1));
      s0_cfg = 8'($urandom & $urandom);
      s1_cfg = 8'($urandom & $urandom) & ~s0_cfg;
      tri_float = 1'($urandom_range(0, 1));
      repeat (6) @(negedge clk);
      drive_start(u5, 1'b1);
      run_once(u5, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
